// File: rtl/tl_tx_arbiter.sv
// TL TX scheduler: P/NP round-robin (strict P priority with TL_TX_STRICT_P_PRIORITY_EN), PH/PD/NPH credit gated.
// Latency: one IDLE decision cycle per TLP, header beat the cycle after grant, data beats at full rate.
// Backpressure: beats held stable while tlp_ready_i is low; an empty P data FIFO stalls the DATA phase.
module tl_tx_arbiter #(
    parameter int FC_HDR_W  = 8,
    parameter int FC_DATA_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p_hdr_empty_i,
    input  logic [127:0]         p_hdr_rdata_i,
    output logic                 p_hdr_rden_o,
    input  logic                 p_data_empty_i,
    input  logic [255:0]         p_data_rdata_i,
    output logic                 p_data_rden_o,
    input  logic                 np_hdr_empty_i,
    input  logic [127:0]         np_hdr_rdata_i,
    output logic                 np_hdr_rden_o,
    input  logic                 fc_update_i,
    input  logic [FC_HDR_W-1:0]  fc_ph_limit_i,
    input  logic [FC_DATA_W-1:0] fc_pd_limit_i,
    input  logic [FC_HDR_W-1:0]  fc_nph_limit_i,
    output logic                 tlp_valid_o,
    output logic [255:0]         tlp_data_o,
    output logic                 tlp_sop_o,
    output logic                 tlp_eop_o,
    input  logic                 tlp_ready_i,
    output logic [FC_HDR_W-1:0]  fc_ph_cons_o,
    output logic [FC_DATA_W-1:0] fc_pd_cons_o,
    output logic [FC_HDR_W-1:0]  fc_nph_cons_o
);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    localparam logic [FC_HDR_W-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_W-1){1'b0}}};
    localparam logic [FC_DATA_W-1:0] DATA_HALF = {1'b1, {(FC_DATA_W-1){1'b0}}};

    state_t               r_state, w_state_nxt;
    logic [FC_HDR_W-1:0]  r_ph_lim, r_nph_lim, r_ph_cons, r_nph_cons;
    logic [FC_DATA_W-1:0] r_pd_lim, r_pd_cons, r_pd_req;
    logic                 r_gnt_np;
    logic [7:0]           r_beats_left;

    logic [9:0]           w_p_len10;
    logic [10:0]          w_p_len_dw;
    logic [FC_DATA_W-1:0] w_pd_req;
    logic [7:0]           w_p_beats;
    logic [FC_HDR_W-1:0]  w_ph_room, w_nph_room;
    logic [FC_DATA_W-1:0] w_pd_room;
    logic                 w_p_elig, w_np_elig, w_pick_np, w_data_acc;

    assign w_p_len10  = {p_hdr_rdata_i[17:16], p_hdr_rdata_i[31:24]};
    assign w_p_len_dw = (w_p_len10 == 10'd0) ? 11'd1024 : {1'b0, w_p_len10};
    assign w_pd_req   = FC_DATA_W'((w_p_len_dw + 11'd3) >> 2);
    assign w_p_beats  = 8'((w_p_len_dw + 11'd7) >> 3);

    // Room left after this TLP, modulo counter width; "negative" lands above half range.
    assign w_ph_room  = r_ph_lim  - r_ph_cons  - FC_HDR_W'(1);
    assign w_nph_room = r_nph_lim - r_nph_cons - FC_HDR_W'(1);
    assign w_pd_room  = r_pd_lim  - r_pd_cons  - w_pd_req;

    assign w_p_elig   = !p_hdr_empty_i && (w_ph_room <= HDR_HALF) && (w_pd_room <= DATA_HALF);
    assign w_np_elig  = !np_hdr_empty_i && (w_nph_room <= HDR_HALF);
    assign w_data_acc = (r_state == DATA) && !p_data_empty_i && tlp_ready_i;

`ifdef TL_TX_STRICT_P_PRIORITY_EN
    assign w_pick_np = !w_p_elig;
`else
    logic r_rr_np;
    assign w_pick_np = w_np_elig && (!w_p_elig || r_rr_np);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_np <= 1'b0;
        end else if (r_state == HDR && tlp_ready_i) begin
            r_rr_np <= !r_gnt_np;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_p_elig || w_np_elig) w_state_nxt = HDR;
            HDR:     if (tlp_ready_i) w_state_nxt = r_gnt_np ? IDLE : DATA;
            DATA:    if (w_data_acc && r_beats_left == 8'd1) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph_lim     <= '0;
            r_pd_lim     <= '0;
            r_nph_lim    <= '0;
            r_ph_cons    <= '0;
            r_pd_cons    <= '0;
            r_nph_cons   <= '0;
            r_pd_req     <= '0;
            r_gnt_np     <= 1'b0;
            r_beats_left <= '0;
        end else begin
            if (fc_update_i) begin
                r_ph_lim  <= fc_ph_limit_i;
                r_pd_lim  <= fc_pd_limit_i;
                r_nph_lim <= fc_nph_limit_i;
            end
            case (r_state)
                IDLE: if (w_p_elig || w_np_elig) begin
                    r_gnt_np     <= w_pick_np;
                    r_beats_left <= w_p_beats;
                    r_pd_req     <= w_pd_req;
                end
                HDR: if (tlp_ready_i) begin
                    if (r_gnt_np) begin
                        r_nph_cons <= r_nph_cons + FC_HDR_W'(1);
                    end else begin
                        r_ph_cons <= r_ph_cons + FC_HDR_W'(1);
                        r_pd_cons <= r_pd_cons + r_pd_req;
                    end
                end
                DATA: if (w_data_acc) r_beats_left <= r_beats_left - 8'd1;
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so no FIFO pop escapes in the reset cycle.
    always_comb begin
        tlp_valid_o   = 1'b0;
        tlp_data_o    = '0;
        tlp_sop_o     = 1'b0;
        tlp_eop_o     = 1'b0;
        p_hdr_rden_o  = 1'b0;
        p_data_rden_o = 1'b0;
        np_hdr_rden_o = 1'b0;
        if (rst_n) begin
            case (r_state)
                HDR: begin
                    tlp_valid_o   = 1'b1;
                    tlp_sop_o     = 1'b1;
                    tlp_eop_o     = r_gnt_np;
                    tlp_data_o    = {128'b0, (r_gnt_np ? np_hdr_rdata_i : p_hdr_rdata_i)};
                    p_hdr_rden_o  = tlp_ready_i && !r_gnt_np;
                    np_hdr_rden_o = tlp_ready_i && r_gnt_np;
                end
                DATA: begin
                    tlp_valid_o   = !p_data_empty_i;
                    tlp_data_o    = p_data_rdata_i;
                    tlp_eop_o     = (r_beats_left == 8'd1);
                    p_data_rden_o = w_data_acc;
                end
                default: ;
            endcase
        end
    end

    assign fc_ph_cons_o  = r_ph_cons;
    assign fc_pd_cons_o  = r_pd_cons;
    assign fc_nph_cons_o = r_nph_cons;

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Directed bench for tl_tx_arbiter: FIFO models feed the DUT, an expected-beat queue checks the TLP stream.
module tb_tl_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p_hdr_empty, p_data_empty, np_hdr_empty;
    logic [127:0] p_hdr_rdata, np_hdr_rdata;
    logic [255:0] p_data_rdata;
    logic         p_hdr_rden, p_data_rden, np_hdr_rden;
    logic         fc_update;
    logic [7:0]   fc_ph_limit, fc_nph_limit;
    logic [11:0]  fc_pd_limit;
    logic         tlp_valid, tlp_sop, tlp_eop, tlp_ready;
    logic [255:0] tlp_data;
    logic [7:0]   fc_ph_cons, fc_nph_cons;
    logic [11:0]  fc_pd_cons;

    always #5 clk = ~clk;

    tl_tx_arbiter #(.FC_HDR_W(8), .FC_DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_hdr_empty_i(p_hdr_empty), .p_hdr_rdata_i(p_hdr_rdata), .p_hdr_rden_o(p_hdr_rden),
        .p_data_empty_i(p_data_empty), .p_data_rdata_i(p_data_rdata), .p_data_rden_o(p_data_rden),
        .np_hdr_empty_i(np_hdr_empty), .np_hdr_rdata_i(np_hdr_rdata), .np_hdr_rden_o(np_hdr_rden),
        .fc_update_i(fc_update), .fc_ph_limit_i(fc_ph_limit), .fc_pd_limit_i(fc_pd_limit),
        .fc_nph_limit_i(fc_nph_limit),
        .tlp_valid_o(tlp_valid), .tlp_data_o(tlp_data), .tlp_sop_o(tlp_sop), .tlp_eop_o(tlp_eop),
        .tlp_ready_i(tlp_ready),
        .fc_ph_cons_o(fc_ph_cons), .fc_pd_cons_o(fc_pd_cons), .fc_nph_cons_o(fc_nph_cons)
    );

    typedef struct {
        logic [255:0] dat;
        logic         sop;
        logic         eop;
    } beat_t;

    beat_t        sb[$];
    logic [127:0] qph[$];
    logic [127:0] qnph[$];
    logic [255:0] qpd[$];

    int checks = 0, failures = 0;
    int m_ph = 0, m_pd = 0, m_nph = 0;
    int n_acc = 0, n_sop = 0, n_dat = 0, n_hrden = 0, n_drden = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_dat;
    logic         prev_sop, prev_eop;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [31:0] tag, input logic [9:0] len);
        logic [127:0] h;
        h          = '0;
        h[127:96]  = tag;
        h[31:24]   = len[7:0];
        h[17:16]   = len[9:8];
        return h;
    endfunction

    function automatic int len_dw(input logic [127:0] h);
        int l;
        l = int'({h[17:16], h[31:24]});
        return (l == 0) ? 1024 : l;
    endfunction

    function automatic logic [255:0] mk_dat(input logic [127:0] h, input int k);
        return {h[127:96], 192'h0, 32'(k)};
    endfunction

    task automatic set_fifo_outs();
        p_hdr_empty  = (qph.size() == 0);
        p_hdr_rdata  = (qph.size() != 0) ? qph[0] : '0;
        np_hdr_empty = (qnph.size() == 0);
        np_hdr_rdata = (qnph.size() != 0) ? qnph[0] : '0;
        p_data_empty = (qpd.size() == 0);
        p_data_rdata = (qpd.size() != 0) ? qpd[0] : '0;
    endtask

    task automatic push_p(input logic [127:0] h, input int from, input int upto);
        if (from == 0) qph.push_back(h);
        for (int k = from; k < upto; k++) qpd.push_back(mk_dat(h, k));
        set_fifo_outs();
    endtask

    task automatic push_np(input logic [127:0] h);
        qnph.push_back(h);
        set_fifo_outs();
    endtask

    task automatic exp_p(input logic [127:0] h);
        int nb;
        nb = (len_dw(h) + 7) / 8;
        sb.push_back('{dat: {128'b0, h}, sop: 1'b1, eop: 1'b0});
        for (int k = 0; k < nb; k++)
            sb.push_back('{dat: mk_dat(h, k), sop: 1'b0, eop: (k == nb - 1)});
    endtask

    task automatic exp_np(input logic [127:0] h);
        sb.push_back('{dat: {128'b0, h}, sop: 1'b1, eop: 1'b1});
    endtask

    // One clock: sample mid-cycle, compare accepted beat, then apply FIFO pops after the edge.
    task automatic tick();
        beat_t e;
        logic  hr, dr, nr;
        #2;
        if (prev_stall) begin
            chk("hold_valid", 256'(tlp_valid), 256'(1'b1));
            chk("hold_data", tlp_data, prev_dat);
            chk("hold_sop", 256'(tlp_sop), 256'(prev_sop));
            chk("hold_eop", 256'(tlp_eop), 256'(prev_eop));
        end
        prev_stall = tlp_valid && !tlp_ready;
        prev_dat   = tlp_data;
        prev_sop   = tlp_sop;
        prev_eop   = tlp_eop;
        if (tlp_valid && tlp_ready) begin
            n_acc++;
            chk("beat_expected", 256'(sb.size() != 0), 256'(1'b1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_data", tlp_data, e.dat);
                chk("beat_sop", 256'(tlp_sop), 256'(e.sop));
                chk("beat_eop", 256'(tlp_eop), 256'(e.eop));
                if (e.sop) begin
                    n_sop++;
                    if (e.eop) m_nph++;
                    else begin
                        m_ph++;
                        m_pd += (len_dw(e.dat[127:0]) + 3) / 4;
                    end
                end else n_dat++;
            end
        end
        hr = p_hdr_rden;
        dr = p_data_rden;
        nr = np_hdr_rden;
        n_hrden += int'(hr) + int'(nr);
        n_drden += int'(dr);
        @(posedge clk);
        #1;
        if (hr && qph.size() != 0)  qph.delete(0);
        if (nr && qnph.size() != 0) qnph.delete(0);
        if (dr && qpd.size() != 0)  qpd.delete(0);
        set_fifo_outs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 256'(sb.size()), 256'(0));
    endtask

    task automatic no_valid(input string tag, input int cycles);
        repeat (cycles) begin
            #1;
            chk(tag, 256'(tlp_valid), 256'(1'b0));
            tick();
        end
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (n_acc < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 256'(n_acc >= target), 256'(1'b1));
    endtask

    task automatic fc(input int ph, input int pd, input int nph);
        fc_ph_limit  = 8'(ph);
        fc_pd_limit  = 12'(pd);
        fc_nph_limit = 8'(nph);
        fc_update    = 1'b1;
        tick();
        fc_update    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tlp_ready  = 1'b1;
        fc_update  = 1'b0;
        tick();
        tick();
        qph.delete();
        qnph.delete();
        qpd.delete();
        sb.delete();
        set_fifo_outs();
        m_ph = 0;
        m_pd = 0;
        m_nph = 0;
        prev_stall = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic chk_cons(input string tag);
        #1;
        chk({tag, "_ph"},  256'(fc_ph_cons),  256'(8'(m_ph)));
        chk({tag, "_pd"},  256'(fc_pd_cons),  256'(12'(m_pd)));
        chk({tag, "_nph"}, 256'(fc_nph_cons), 256'(8'(m_nph)));
    endtask

    initial begin
        logic [127:0] h, hn;
        int a0, h0, d0, pd0;
        rst_n = 1'b0;
        tlp_ready = 1'b1;
        fc_update = 1'b0;
        fc_ph_limit = '0;
        fc_pd_limit = '0;
        fc_nph_limit = '0;
        set_fifo_outs();
        @(posedge clk);
        #1;

        // 1: credits start at zero, first update releases one P TLP
        do_reset();
        chk("rst_valid", 256'(tlp_valid), 256'(1'b0));
        chk("rst_rden", 256'({p_hdr_rden, p_data_rden, np_hdr_rden}), 256'(3'b000));
        chk("rst_ph_cons", 256'(fc_ph_cons), 256'(0));
        chk("rst_pd_cons", 256'(fc_pd_cons), 256'(0));
        h = mk_hdr(32'h1, 10'd16);
        push_p(h, 0, 2);
        exp_p(h);
        no_valid("t1_no_credit", 20);
        fc(1, 4, 0);
        drain("t1_drain", 40);
        chk("t1_ph", 256'(fc_ph_cons), 256'(8'd1));
        chk("t1_pd", 256'(fc_pd_cons), 256'(12'd4));

        // 2: arbitration order with everything eligible
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_p(mk_hdr(32'h10 + 32'(i), 10'd8), 0, 1);
            push_np(mk_hdr(32'h20 + 32'(i), 10'd1));
        end
`ifdef TL_TX_STRICT_P_PRIORITY_EN
        for (int i = 0; i < 3; i++) exp_p(mk_hdr(32'h10 + 32'(i), 10'd8));
        for (int i = 0; i < 3; i++) exp_np(mk_hdr(32'h20 + 32'(i), 10'd1));
`else
        for (int i = 0; i < 3; i++) begin
            exp_p(mk_hdr(32'h10 + 32'(i), 10'd8));
            exp_np(mk_hdr(32'h20 + 32'(i), 10'd1));
        end
`endif
        fc(8, 64, 8);
        drain("t2_drain", 80);
        chk_cons("t2");
        chk("t2_pd_abs", 256'(fc_pd_cons), 256'(12'd6));

        // 3: PD shortfall lets NP pass, P waits for the update
        do_reset();
        h  = mk_hdr(32'h30, 10'd16);
        hn = mk_hdr(32'h31, 10'd1);
        push_p(h, 0, 2);
        push_np(hn);
        exp_np(hn);
        fc(8, 3, 8);
        drain("t3_np", 20);
        no_valid("t3_p_held", 8);
        exp_p(h);
        fc(8, 7, 8);
        drain("t3_p", 30);
        chk_cons("t3");

        // 4: backpressure on header and mid-data
        do_reset();
        tlp_ready = 1'b0;
        h = mk_hdr(32'h40, 10'd24);
        push_p(h, 0, 3);
        exp_p(h);
        a0 = n_acc;
        h0 = n_hrden;
        d0 = n_drden;
        fc(8, 64, 8);
        repeat (3) tick();
        #1;
        chk("t4_hdr_valid", 256'({tlp_valid, tlp_sop}), 256'(2'b11));
        repeat (5) tick();
        tlp_ready = 1'b1;
        wait_acc("t4_first_data", a0 + 2, 20);
        tlp_ready = 1'b0;
        repeat (3) tick();
        tlp_ready = 1'b1;
        drain("t4_drain", 20);
        chk("t4_beats", 256'(n_acc - a0), 256'(4));
        chk("t4_hdr_rden", 256'(n_hrden - h0), 256'(1));
        chk("t4_data_rden", 256'(n_drden - d0), 256'(3));

        // 5: data underflow stall, then a 1024 DW TLP
        do_reset();
        h = mk_hdr(32'h50, 10'd24);
        push_p(h, 0, 1);
        exp_p(h);
        a0 = n_acc;
        fc(8, 64, 8);
        wait_acc("t5_first_data", a0 + 2, 20);
        repeat (4) begin
            #1;
            chk("t5_underflow_valid", 256'(tlp_valid), 256'(1'b0));
            chk("t5_underflow_rden", 256'(p_data_rden), 256'(1'b0));
            tick();
        end
        push_p(h, 1, 3);
        drain("t5_resume", 20);
        h = mk_hdr(32'h51, 10'd0);
        push_p(h, 0, 128);
        exp_p(h);
        pd0 = m_pd;
        d0  = n_dat;
        fc(m_ph + 1, m_pd + 256, 8);
        drain("t5_len0", 300);
        chk("t5_len0_beats", 256'(n_dat - d0), 256'(128));
        chk("t5_len0_pd", 256'(fc_pd_cons), 256'(12'(pd0 + 256)));
        chk_cons("t5");

        // 6: PH counter wrap, blocking at the limit, reset mid-DATA
        do_reset();
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < 10; i++) begin
                h = mk_hdr(32'h100 + 32'(b * 10 + i), 10'd8);
                push_p(h, 0, 1);
                exp_p(h);
            end
            fc(m_ph + 10, m_pd + 20, 0);
            drain("t6_fill", 60);
        end
        chk("t6_ph250", 256'(fc_ph_cons), 256'(8'd250));
        for (int i = 0; i < 11; i++) begin
            h = mk_hdr(32'h300 + 32'(i), 10'd8);
            push_p(h, 0, 1);
            if (i < 10) exp_p(h);
        end
        fc(4, 540, 0);
        drain("t6_wrap", 80);
        no_valid("t6_blocked", 10);
        chk("t6_ph_wrapped", 256'(fc_ph_cons), 256'(8'd4));
        chk_cons("t6");
        exp_p(mk_hdr(32'h30a, 10'd8));
        a0 = n_acc;
        fc(5, 540, 0);
        wait_acc("t6_hdr_acc", a0 + 1, 20);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_rden", 256'({p_hdr_rden, p_data_rden, np_hdr_rden}), 256'(3'b000));
        chk("t6_rst_valid", 256'(tlp_valid), 256'(1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_post_rst_out", 256'({tlp_valid, tlp_sop, tlp_eop}), 256'(3'b000));
        chk("t6_post_rst_data", tlp_data, 256'(0));
        chk("t6_post_rst_cons", 256'({fc_ph_cons, fc_pd_cons, fc_nph_cons}), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_tx_arbiter.md
Name: tl_tx_arbiter

Overview:
- Transaction-layer TX scheduler. Drains the posted (P) header FIFO, the P data FIFO and the non-posted (NP) header FIFO that the AXI slave packer fills, and serialises whole TLPs onto one 256-bit stream toward the data-link layer.
- Gates each TLP on PCIe flow-control credits: PH, PD and NPH.
- Arbitrates P vs NP round-robin at TLP granularity.

Parameters:
- FC_HDR_W, 8, width of header credit counters (PH, NPH); modulo-2^8 arithmetic.
- FC_DATA_W, 12, width of data credit counter (PD); 1 credit = 16 B (4 DW).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- p_hdr_empty_i  in  1  P header FIFO empty.
- p_hdr_rdata_i  in  128  P header, show-ahead.
- p_hdr_rden_o  out  1  pop P header.
- p_data_empty_i  in  1  P data FIFO empty.
- p_data_rdata_i  in  256  P data beat, show-ahead.
- p_data_rden_o  out  1  pop P data.
- np_hdr_empty_i  in  1  NP header FIFO empty.
- np_hdr_rdata_i  in  128  NP header, show-ahead.
- np_hdr_rden_o  out  1  pop NP header.
- fc_update_i  in  1  pulse: load the three credit limits below.
- fc_ph_limit_i  in  FC_HDR_W  PH credit limit.
- fc_pd_limit_i  in  FC_DATA_W  PD credit limit.
- fc_nph_limit_i  in  FC_HDR_W  NPH credit limit.
- tlp_valid_o  out  1  beat valid.
- tlp_data_o  out  256  beat data.
- tlp_sop_o  out  1  first beat of TLP.
- tlp_eop_o  out  1  last beat of TLP.
- tlp_ready_i  in  1  downstream accepts beat.
- fc_ph_cons_o  out  FC_HDR_W  PH credits consumed (debug).
- fc_pd_cons_o  out  FC_DATA_W  PD credits consumed (debug).
- fc_nph_cons_o  out  FC_HDR_W  NPH credits consumed (debug).

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state IDLE; all limit and consumed registers 0; rr pointer = P; all outputs 0.
- Header length field: len = {hdr[17:16], hdr[31:24]} in DW; len==0 means 1024.
- Required credits:
  - P TLP: 1 PH and ceil(len/4) PD.
  - NP TLP: 1 NPH.
  - Data beats for P: ceil(len/8).
- Credit check, per type, using counter width N: eligible iff (limit - (cons + req)) mod 2^N <= 2^(N-1).
  - With limits 0 after reset, nothing is eligible until the first fc_update_i.
- Eligibility:
  - P requires !p_hdr_empty_i plus PH and PD credits.
  - NP requires !np_hdr_empty_i plus NPH credit.
  - P data availability is not checked at grant; data underflow stalls in DATA.
- FSM states IDLE, HDR, DATA:
  - IDLE: if both types eligible, grant rr; otherwise grant the eligible one. Register grant and beat count; go HDR. No outputs asserted in IDLE.
  - HDR: tlp_valid_o=1, tlp_sop_o=1, tlp_data_o={128'b0, hdr}; tlp_eop_o=1 iff NP.
    - On tlp_ready_i: pop the granted header FIFO (1-cycle rden), add req to the cons counters, flip rr to the other type.
    - Next state: NP goes to IDLE; P goes to DATA.
  - DATA: tlp_valid_o = !p_data_empty_i; tlp_data_o = p_data_rdata_i; tlp_eop_o when remaining==1.
    - On valid&ready: p_data_rden_o=1 and remaining decrements.
    - Last beat accepted returns to IDLE.
- Output stability: tlp_data_o and control are held stable while valid&!ready. The header beat content is taken from FIFO show-ahead data and must not change until popped.
- Latency and throughput:
  - 1 idle cycle between TLPs (IDLE decision cycle).
  - Header beat appears the cycle after the grant.
  - Back-to-back data beats at full rate.
- fc_update_i:
  - Loads the limits at the clock edge.
  - Takes effect on the eligibility check from the next cycle.
  - Simultaneous update and consume are both applied.
- Wrap: cons counters wrap modulo 2^N; the check remains correct across wrap.
- Reset mid-TLP: immediate return to IDLE with counters cleared; no rden is asserted in the reset cycle.

Optional Feature:
- Macro: TL_TX_STRICT_P_PRIORITY_EN.
- Defined: P always wins when both types are eligible; rr pointer unused. NP is granted only when P is not eligible.
- Undefined: round-robin as above.

Test Plan:
1. Reset, then P hdr len=16 with 2 data beats queued, no fc_update → no tlp_valid_o for 20 cycles. Then fc_update with PH=1, PD=4 → HDR beat (sop), 2 data beats (eop on 2nd). fc_ph_cons_o=1, fc_pd_cons_o=4.
2. Limits PH=8, PD=64, NPH=8; 3 P and 3 NP queued, all eligible → TLP order P,NP,P,NP,P,NP. With TL_TX_STRICT_P_PRIORITY_EN: P,P,P,NP,NP,NP.
3. PD limit=3, P len=16 (needs 4) and NP pending → NP sent, P held. fc_update PD=7 → P sent.
4. tlp_ready_i low for 5 cycles on the header beat and 3 cycles mid-data → beats held stable; exactly one rden per accepted beat; total beats = 1 + ceil(len/8).
5. P data FIFO empty during DATA for 4 cycles → tlp_valid_o=0 with no pop; resume on non-empty. Also len=0 (1024 DW) → 128 data beats, 256 PD credits.
6. Cons PH=250, limit PH wraps to 4, 10 P TLPs → all 10 sent. PH cons ends at 4 and the 11th P TLP is blocked. Assert rst_n low mid-DATA → outputs 0 and state IDLE next cycle.
